// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants: word width, NOP encoding,
// the fetch queue entry layout and the default reset PC.
package cpu_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] INSTR_NOP = 32'hE1A0_0000;
  localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries. Flush beats push; a full queue accepts
// a push in the same cycle as a pop. Head entry reads as zero when empty.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  push_entry,
  output fetch_entry_t  head_entry,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  fetch_entry_t  slots [DEPTH];
  logic [PW-1:0] head_reg;
  logic [PW-1:0] tail_reg;
  logic [CW-1:0] count_reg;
  logic          do_pop;
  logic          do_push;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign count   = count_reg;
  assign do_pop  = pop & ~empty;
  assign do_push = push & ~flush & (~full | do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (do_push) tail_reg <= tail_reg + PW'(1);
      if (do_pop)  head_reg <= head_reg + PW'(1);
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) slots[tail_reg] <= push_entry;
  end

  assign head_entry = empty ? '0 : slots[head_reg];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, prefetch queue and branch redirect.
// Optional macro FETCH_ALIGN_CHECK_EN adds fetch_fault for misaligned branch targets.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                MEM_BYTES   = 1024,
  parameter logic [WORD_W-1:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int                QUEUE_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic [WORD_W-1:0] imem_address,
  input  logic [WORD_W-1:0] imem_read_data,
  input  logic              branch_valid,
  input  logic [WORD_W-1:0] branch_target,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] instr_pc,
  output logic              fetch_halted
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic              fetch_fault
`endif
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [WORD_W-1:0] PC_LIMIT = WORD_W'(MEM_BYTES - 3);

  logic [WORD_W-1:0] pc_reg, pc_next;
  logic              halted_reg, halted_next;
  logic              in_range;
  logic              pop;
  logic              push;
  fetch_entry_t      push_entry;
  fetch_entry_t      head_entry;
  logic [CW-1:0]     q_count;
  logic              q_empty;
  logic              q_full;
  logic              unused_full;

  assign unused_full  = q_full;
  assign in_range     = (pc_reg < PC_LIMIT);
  assign instr_valid  = ~q_empty;
  assign pop          = instr_valid & instr_ready;
  assign push         = ~branch_valid & ~halted_reg & in_range
                      & ((q_count < CW'(QUEUE_DEPTH)) | pop);
  assign push_entry   = '{pc: pc_reg, instr: imem_read_data};
  assign imem_address = pc_reg;
  assign instr        = head_entry.instr;
  assign instr_pc     = head_entry.pc;
  assign fetch_halted = halted_reg;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_reg, fault_next;
  logic misaligned;
  assign misaligned  = (branch_target[1:0] != 2'b00);
  assign fetch_fault = fault_reg;
`else
  logic unused_align;
  assign unused_align = ^branch_target[1:0];
`endif

  always_comb begin
    pc_next     = pc_reg;
    halted_next = halted_reg;
`ifdef FETCH_ALIGN_CHECK_EN
    fault_next  = fault_reg;
`endif
    if (branch_valid) begin
`ifdef FETCH_ALIGN_CHECK_EN
      // A misaligned target parks the PC there and blocks fetch until an aligned branch.
      pc_next     = branch_target;
      halted_next = misaligned;
      fault_next  = misaligned;
`else
      pc_next     = {branch_target[WORD_W-1:2], 2'b00};
      halted_next = 1'b0;
`endif
    end else if (push) begin
      pc_next = pc_reg + 32'd4;
    end else if (!in_range) begin
      halted_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg     <= RESET_PC;
      halted_reg <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_reg  <= 1'b0;
`endif
    end else begin
      pc_reg     <= pc_next;
      halted_reg <= halted_next;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_reg  <= fault_next;
`endif
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (branch_valid),
    .push_entry (push_entry),
    .head_entry (head_entry),
    .count      (q_count),
    .empty      (q_empty),
    .full       (q_full)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector table, then
// randomized traffic against a queue-based reference model.
module tb_instr_fetch_unit;
  import cpu_pkg::*;

  localparam int MEM_BYTES   = 256;
  localparam int QUEUE_DEPTH = 2;
  localparam logic [31:0] LIMIT = 32'(MEM_BYTES - 3);

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_address;
  logic [31:0] imem_read_data;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_halted;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Distinct, address-dependent instruction memory contents.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return ((a ^ 32'h5A5A_0000) * 32'h0001_0003) + 32'h0000_1234;
  endfunction

  assign imem_read_data = word_at(imem_address);

  instr_fetch_unit #(
    .MEM_BYTES   (MEM_BYTES),
    .RESET_PC    (32'h0000_0000),
    .QUEUE_DEPTH (QUEUE_DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_address   (imem_address),
    .imem_read_data (imem_read_data),
    .branch_valid   (branch_valid),
    .branch_target  (branch_target),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .fetch_halted   (fetch_halted)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .fetch_fault    (fetch_fault)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          br;
    logic [31:0] tgt;
    bit          rdy;
    bit          e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_addr;
    bit          e_halt;
    bit          e_fault;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit br, input logic [31:0] tgt, input bit rdy, input bit v,
                     input logic [31:0] pc, input logic [31:0] addr, input bit h, input bit f);
    vec_t r;
    r = '{br: br, tgt: tgt, rdy: rdy, e_valid: v, e_pc: pc, e_addr: addr, e_halt: h, e_fault: f};
    tbl.push_back(r);
  endtask

  // Reference model: a plain FIFO of {pc, word} plus pc/halt/fault flags.
  logic [31:0]  m_pc;
  fetch_entry_t m_q[$];
  bit           m_halted;
  bit           m_fault;

  task automatic model_reset();
    m_pc = 32'h0; m_q.delete(); m_halted = 0; m_fault = 0;
  endtask

  task automatic model_step(input bit br, input logic [31:0] tgt, input bit rdy);
    bit pop;
    bit had_room;
    fetch_entry_t e;
    pop      = (m_q.size() != 0) && rdy;
    had_room = (m_q.size() < QUEUE_DEPTH);
    if (pop) void'(m_q.pop_front());
    if (br) begin
      m_q.delete();
`ifdef FETCH_ALIGN_CHECK_EN
      m_pc     = tgt;
      m_fault  = (tgt % 4) != 0;
      m_halted = m_fault;
`else
      m_pc     = tgt - (tgt % 4);
      m_halted = 0;
`endif
    end else if (!m_halted && m_pc < LIMIT && (had_room || pop)) begin
      e.pc = m_pc; e.instr = word_at(m_pc);
      m_q.push_back(e);
      m_pc = m_pc + 4;
    end else if (m_pc >= LIMIT) begin
      m_halted = 1;
    end
  endtask

  task automatic check_model(input int cyc);
    bit v;
    v = (m_q.size() != 0);
    chk($sformatf("rnd%0d_valid", cyc), 32'(instr_valid), 32'(v));
    chk($sformatf("rnd%0d_pc", cyc), instr_pc, v ? m_q[0].pc : 32'h0);
    chk($sformatf("rnd%0d_instr", cyc), instr, v ? m_q[0].instr : 32'h0);
    chk($sformatf("rnd%0d_addr", cyc), imem_address, m_pc);
    chk($sformatf("rnd%0d_halt", cyc), 32'(fetch_halted), 32'(m_halted));
`ifdef FETCH_ALIGN_CHECK_EN
    chk($sformatf("rnd%0d_fault", cyc), 32'(fetch_fault), 32'(m_fault));
`endif
  endtask

  initial begin
    bit          br, rdy;
    logic [31:0] tgt;
    int          sel;

    reset = 1'b1; branch_valid = 1'b0; branch_target = '0; instr_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_valid", 32'(instr_valid), 32'h0);
    chk("reset_instr", instr, 32'h0);
    chk("reset_instr_pc", instr_pc, 32'h0);
    chk("reset_addr", imem_address, 32'h0);
    chk("reset_halt", 32'(fetch_halted), 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("reset_fault", 32'(fetch_fault), 32'h0);
`endif

    // br, tgt, rdy | valid, pc, addr, halt, fault
    add(0, 32'h00, 0, 0, 32'h00, 32'h00, 0, 0);
    add(0, 32'h00, 0, 1, 32'h00, 32'h04, 0, 0);
    add(0, 32'h00, 0, 1, 32'h00, 32'h08, 0, 0);
    add(0, 32'h00, 0, 1, 32'h00, 32'h08, 0, 0);
    add(0, 32'h00, 0, 1, 32'h00, 32'h08, 0, 0);
    add(0, 32'h00, 1, 1, 32'h00, 32'h08, 0, 0);
    add(0, 32'h00, 1, 1, 32'h04, 32'h0C, 0, 0);
    add(1, 32'h40, 0, 1, 32'h08, 32'h10, 0, 0);
    add(0, 32'h00, 1, 0, 32'h00, 32'h40, 0, 0);
    add(0, 32'h00, 1, 1, 32'h40, 32'h44, 0, 0);
    add(0, 32'h00, 0, 1, 32'h44, 32'h48, 0, 0);
    add(1, 32'h80, 1, 1, 32'h44, 32'h4C, 0, 0);
    add(0, 32'h00, 1, 0, 32'h00, 32'h80, 0, 0);
    add(1, 32'hF0, 1, 1, 32'h80, 32'h84, 0, 0);
    add(0, 32'h00, 1, 0, 32'h00, 32'hF0, 0, 0);
    add(0, 32'h00, 1, 1, 32'hF0, 32'hF4, 0, 0);
    add(0, 32'h00, 1, 1, 32'hF4, 32'hF8, 0, 0);
    add(0, 32'h00, 1, 1, 32'hF8, 32'hFC, 0, 0);
    add(0, 32'h00, 1, 1, 32'hFC, 32'h100, 0, 0);
    add(0, 32'h00, 1, 0, 32'h00, 32'h100, 1, 0);
    add(1, 32'h00, 1, 0, 32'h00, 32'h100, 1, 0);
    add(0, 32'h00, 1, 0, 32'h00, 32'h00, 0, 0);
    add(1, 32'h22, 1, 1, 32'h00, 32'h04, 0, 0);
`ifdef FETCH_ALIGN_CHECK_EN
    add(0, 32'h00, 1, 0, 32'h00, 32'h22, 1, 1);
    add(1, 32'h20, 1, 0, 32'h00, 32'h22, 1, 1);
`else
    add(0, 32'h00, 1, 0, 32'h00, 32'h20, 0, 0);
    add(1, 32'h20, 1, 1, 32'h20, 32'h24, 0, 0);
`endif
    add(0, 32'h00, 1, 0, 32'h00, 32'h20, 0, 0);
    add(0, 32'h00, 1, 1, 32'h20, 32'h24, 0, 0);

    reset = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      branch_valid  = tbl[i].br;
      branch_target = tbl[i].tgt;
      instr_ready   = tbl[i].rdy;
      chk($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(tbl[i].e_valid));
      chk($sformatf("vec%0d_pc", i), instr_pc, tbl[i].e_pc);
      chk($sformatf("vec%0d_instr", i), instr, tbl[i].e_valid ? word_at(tbl[i].e_pc) : 32'h0);
      chk($sformatf("vec%0d_addr", i), imem_address, tbl[i].e_addr);
      chk($sformatf("vec%0d_halt", i), 32'(fetch_halted), 32'(tbl[i].e_halt));
`ifdef FETCH_ALIGN_CHECK_EN
      chk($sformatf("vec%0d_fault", i), 32'(fetch_fault), 32'(tbl[i].e_fault));
`endif
      $display("vec %0d br=%0b tgt=%h rdy=%0b valid=%0b pc=%h addr=%h halt=%0b",
               i, tbl[i].br, tbl[i].tgt, tbl[i].rdy, instr_valid, instr_pc, imem_address, fetch_halted);
      @(negedge clk);
    end

    // Asynchronous reset mid-cycle must clear state without waiting for an edge.
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_valid", 32'(instr_valid), 32'h0);
    chk("async_reset_addr", imem_address, 32'h0);
    chk("async_reset_pc", instr_pc, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    for (int c = 0; c < 1500; c++) begin
      br  = ($urandom % 16) == 0;
      sel = int'($urandom % 8);
      if (sel < 6)       tgt = 32'($urandom_range(0, 63)) * 4;
      else if (sel == 6) tgt = 32'(MEM_BYTES - 4 - 4 * int'($urandom_range(0, 3)));
      else               tgt = 32'($urandom_range(0, 255));
      rdy = (c % 200 < 100) ? (($urandom % 4) != 0) : (($urandom % 3) == 0);
      branch_valid  = br;
      branch_target = tgt;
      instr_ready   = rdy;
      check_model(c);
      if (c % 100 == 0)
        $display("rnd %0d br=%0b tgt=%h rdy=%0b valid=%0b pc=%h", c, br, tgt, rdy, instr_valid, instr_pc);
      model_step(br, tgt, rdy);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage between the instruction memory (combinational 32-bit read port, little-endian byte assembly) and the decoder. Holds the PC and drives the memory address. Captures fetched words plus their PCs into a small prefetch queue, presented to decode through a valid/ready handshake. A branch redirect flushes the queue and restarts fetch at the target.

Parameters:
MEM_BYTES, 1024, size of the instruction memory in bytes; fetch legal only while pc < MEM_BYTES-3
RESET_PC, 32'h0000_0000, PC loaded on reset
QUEUE_DEPTH, 2, prefetch queue entries (power of two, >= 2)

Ports:
clk  in  1  clock; all state on posedge
reset  in  1  asynchronous, active-high; clears all state immediately
imem_address  out  32  = pc register (combinational from register)
imem_read_data  in  32  instruction word at imem_address, same cycle
branch_valid  in  1  redirect request this cycle
branch_target  in  32  redirect PC
instr_valid  out  1  queue head valid
instr_ready  in  1  decoder accepts head
instr  out  32  head instruction word; 0 when empty
instr_pc  out  32  head word's PC; 0 when empty
fetch_halted  out  1  fetch stopped at end of memory

Behaviour:
- Reset: pc=RESET_PC, queue empty, instr_valid=0, instr=0, instr_pc=0, fetch_halted=0 (fetch_fault=0 if built).
- pop = instr_valid & instr_ready.
- push = !branch_valid & !fetch_halted & (pc < MEM_BYTES-3) & (count < QUEUE_DEPTH | pop).
- On push: enqueue {pc, imem_read_data}; pc <= pc+4 (32-bit wrap, no carry out).
- Sustained throughput: 1 instr/cycle when decode is always ready. A full queue accepts a push in the same cycle as a pop.
- Latency: first edge after reset release enqueues word@RESET_PC. instr_valid is high from the following cycle.
- Stall: if the queue is full and there is no pop, pc holds and imem_address stays stable. The word is re-read next cycle.
- Branch (branch_valid=1):
  - Queue count <= 0; pc <= branch_target.
  - The word read at the old pc is discarded; fetch_halted <= 0.
  - instr_valid is 0 in the next cycle. The target word is enqueued in that cycle and is valid the cycle after (2-cycle redirect bubble).
- Branch + pop in the same cycle: the pop completes (the consumer owns that word); all other entries are flushed.
- End of memory: when pc >= MEM_BYTES-3 and no branch, no push and fetch_halted <= 1 (registered).
  - Queued entries still drain normally.
  - Only a branch or reset clears the halt.
- Queue ordering is strict FIFO; head/tail pointers wrap modulo QUEUE_DEPTH.
- Outputs instr and instr_pc are registered or taken directly from the head slot; no combinational path from instr_ready to instr_valid.

Optional Feature:
FETCH_ALIGN_CHECK_EN:
- Defined:
  - Adds output fetch_fault (1 bit). A branch with branch_target[1:0] != 0 loads pc and sets fetch_fault=1 and fetch_halted=1.
  - No pushes occur until the next aligned branch, which clears both. Reset clears both.
- Undefined:
  - The port is absent; branch_target[1:0] is ignored and pc loads {branch_target[31:2], 2'b00}.

Decomposition:
- Shared package cpu_pkg:
  - WORD_W=32
  - INSTR_NOP=32'hE1A00000 (MOV R0,R0)
  - typedef fetch_entry_t {pc[31:0], instr[31:0]}
  - DEFAULT_RESET_PC
- Sub-module fetch_queue: parameterised synchronous FIFO of fetch_entry_t.
  - Ports: push, pop, flush, count, head entry, empty/full.
  - Async active-high reset; flush has priority over push.

Test Plan:
- Reset release with instr_ready=1, memory words at 0,4,8 -> instr_valid rises 2nd cycle; instr_pc sequence 0,4,8 on consecutive cycles; instr matches memory.
- instr_ready=0 for 5 cycles -> exactly 2 entries queued (pc 0,4); imem_address holds 8; on release, 0,4,8 are delivered with no gap or duplicate.
- branch_valid with target 0x40 while the queue holds 2 entries -> next cycle instr_valid=0; following cycle instr_pc=0x40; no stale PCs appear.
- branch and pop in the same cycle -> popped entry counted once, remainder dropped, first post-branch instr_pc equals the target.
- MEM_BYTES=16, free-running -> PCs 0,4,8,12 delivered, then fetch_halted=1 and instr_valid=0. A branch to 0 clears the halt and restarts at 0.
- With FETCH_ALIGN_CHECK_EN, branch to 0x22 -> fetch_fault=1, no instr_valid. A branch to 0x20 clears it and delivers instr_pc=0x20. Without the macro, the same branch delivers instr_pc=0x20.
